// File: rtl/taillight_decoder_pkg.sv
// Shared definitions for the tail-light lamp bus: legal lamp patterns, decoder
// state encoding, direction codes and small state-decode helpers. The lamp
// driver FSM imports the same package so both sides agree on the patterns.
package taillight_decoder_pkg;

  // Lamp patterns: left lamps fill from bit 0 upward, right lamps from bit 3.
  localparam logic [5:0] PatIdle = 6'd0;
  localparam logic [5:0] PatL1   = 6'd1;
  localparam logic [5:0] PatL2   = 6'd3;
  localparam logic [5:0] PatL3   = 6'd7;
  localparam logic [5:0] PatR1   = 6'd8;
  localparam logic [5:0] PatR2   = 6'd24;
  localparam logic [5:0] PatR3   = 6'd56;

  localparam logic [1:0] DirIdle  = 2'b00;
  localparam logic [1:0] DirLeft  = 2'b01;
  localparam logic [1:0] DirRight = 2'b10;
  localparam logic [1:0] DirErr   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StL1,
    StL2,
    StL3,
    StR1,
    StR2,
    StR3,
    StErr
  } state_e;

  function automatic logic [1:0] dir_of(state_e s);
    logic [1:0] d;
    case (s)
      StL1, StL2, StL3: d = DirLeft;
      StR1, StR2, StR3: d = DirRight;
      StErr:            d = DirErr;
      default:          d = DirIdle;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] phase_of(state_e s);
    logic [1:0] p;
    case (s)
      StL1, StR1: p = 2'd1;
      StL2, StR2: p = 2'd2;
      StL3, StR3: p = 2'd3;
      default:    p = 2'd0;
    endcase
    return p;
  endfunction

  // True for the states whose dwell time is checked (not IDLE, not ERR).
  function automatic logic is_seq(state_e s);
    return (s != StIdle) && (s != StErr);
  endfunction

endpackage

// File: rtl/taillight_dwell_timer.sv
// Dwell timer for the tail-light decoder. Counts clock cycles since the last
// lamp-bus event (saturating) and flags when the pattern now ending was held
// for fewer than MIN_DWELL cycles.
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   evt        lamp bus changed this cycle (clears the counter)
//   too_short  current pattern held fewer than MIN_DWELL cycles
module taillight_dwell_timer #(
  parameter int unsigned MIN_DWELL = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic evt,
  output logic too_short
);

  localparam int unsigned DW = (MIN_DWELL < 2) ? 1 : $clog2(MIN_DWELL + 1);
  // The counter reads n-1 at the edge that ends an n-cycle hold, since it
  // is cleared on the same edge that first registers the new pattern.
  localparam logic [DW-1:0] Limit = (MIN_DWELL == 0) ? '0 : DW'(MIN_DWELL - 1);
  localparam logic [DW-1:0] One   = DW'(1);

  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (evt) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + One;
    end
  end

  assign too_short = (cnt_q < Limit);

endmodule

// File: rtl/taillight_decoder.sv
// Tail-light lamp-bus checker. Decodes the 6-bit lamp bus into direction and
// sequence phase, checks every pattern change against the legal left/right
// sequences, and counts completed sequences and protocol errors.
// Optional feature macro: TAILLIGHT_DWELL_CHECK_EN enables the minimum dwell
// check (taillight_dwell_timer); without it pattern timing is ignored.
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   lamps      lamp bus from the turn-signal FSM (same clock domain)
//   clr        synchronous clear of counters and sticky err
//   dir        00 idle, 01 left, 10 right, 11 error
//   phase      0 idle/error, 1..3 lamps lit in current sequence
//   done       one-cycle pulse when a legal sequence returns to idle
//   err        sticky protocol-error flag
//   left_cnt   completed left sequences (saturating)
//   right_cnt  completed right sequences (saturating)
//   err_cnt    protocol errors detected (saturating)
module taillight_decoder
  import taillight_decoder_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_DWELL = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       lamps,
  input  logic             clr,
  output logic [1:0]       dir,
  output logic [1:0]       phase,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  if (MIN_DWELL == 0) begin : g_bad_min_dwell
    $error("MIN_DWELL must be nonzero");
  end

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e     state_q, state_d;
  logic [5:0] prev_q;
  logic       lamp_evt;
  logic       done_d, left_inc, right_inc, err_entry;
  logic       dwell_short;

  assign lamp_evt = (lamps != prev_q);

`ifdef TAILLIGHT_DWELL_CHECK_EN
  taillight_dwell_timer #(
    .MIN_DWELL(MIN_DWELL)
  ) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .evt      (lamp_evt),
    .too_short(dwell_short)
  );
`else
  assign dwell_short = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    left_inc  = 1'b0;
    right_inc = 1'b0;
    if (lamp_evt) begin
      case (state_q)
        StIdle: begin
          if (lamps == PatL1)      state_d = StL1;
          else if (lamps == PatR1) state_d = StR1;
          else                     state_d = StErr;
        end
        StL1: state_d = (lamps == PatL2) ? StL2 : StErr;
        StL2: state_d = (lamps == PatL3) ? StL3 : StErr;
        StL3: begin
          if (lamps == PatIdle) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            left_inc = 1'b1;
          end else begin
            state_d = StErr;
          end
        end
        StR1: state_d = (lamps == PatR2) ? StR2 : StErr;
        StR2: state_d = (lamps == PatR3) ? StR3 : StErr;
        StR3: begin
          if (lamps == PatIdle) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            right_inc = 1'b1;
          end else begin
            state_d = StErr;
          end
        end
        StErr:   state_d = (lamps == PatIdle) ? StIdle : StErr;
        default: state_d = StErr;
      endcase
      // A legal step taken too soon is still a protocol error.
      if (dwell_short && is_seq(state_q)) begin
        state_d   = StErr;
        done_d    = 1'b0;
        left_inc  = 1'b0;
        right_inc = 1'b0;
      end
    end
  end

  // Counted once per entry; staying in ERR does not re-count.
  assign err_entry = (state_d == StErr) && (state_q != StErr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      prev_q    <= PatIdle;
      dir       <= DirIdle;
      phase     <= 2'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      left_cnt  <= '0;
      right_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      prev_q  <= lamps;
      state_q <= state_d;
      dir     <= dir_of(state_d);
      phase   <= phase_of(state_d);
      done    <= done_d;
      // clr takes priority over any same-cycle count or error event.
      if (clr) begin
        err       <= 1'b0;
        left_cnt  <= '0;
        right_cnt <= '0;
        err_cnt   <= '0;
      end else begin
        if (err_entry) begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CntOne;
        end
        if (left_inc && (left_cnt != '1))   left_cnt  <= left_cnt + CntOne;
        if (right_inc && (right_cnt != '1)) right_cnt <= right_cnt + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_taillight_decoder.sv
module tb_taillight_decoder;

  localparam int unsigned CNT_W     = 2;
  localparam int unsigned MIN_DWELL = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [5:0]       lamps = 6'd0;
  logic             clr = 1'b0;
  logic [1:0]       dir, phase;
  logic             done, err;
  logic [CNT_W-1:0] left_cnt, right_cnt, err_cnt;

  int total = 0;
  int bad   = 0;
  int done_seen;

  taillight_decoder #(
    .CNT_W    (CNT_W),
    .MIN_DWELL(MIN_DWELL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .lamps    (lamps),
    .clr      (clr),
    .dir      (dir),
    .phase    (phase),
    .done     (done),
    .err      (err),
    .left_cnt (left_cnt),
    .right_cnt(right_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] lamps;
    logic       clr;
    logic [1:0] dir;
    logic [1:0] phase;
    logic       done;
    logic       err;
    int         l;
    int         r;
    int         e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] lp, input logic c, input logic [1:0] d,
                     input logic [1:0] p, input logic dn, input logic er,
                     input int l, input int r, input int e);
    vec_t v;
    v.lamps = lp; v.clr = c; v.dir = d; v.phase = p; v.done = dn; v.err = er;
    v.l = l; v.r = r; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int d, input int p, input int dn,
                           input int er, input int l, input int r, input int e);
    check({tag, ".dir"}, int'(dir), d);
    check({tag, ".phase"}, int'(phase), p);
    check({tag, ".done"}, int'(done), dn);
    check({tag, ".err"}, int'(err), er);
    check({tag, ".left_cnt"}, int'(left_cnt), l);
    check({tag, ".right_cnt"}, int'(right_cnt), r);
    check({tag, ".err_cnt"}, int'(err_cnt), e);
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic step(input logic [5:0] lp, input logic c);
    lamps = lp;
    clr   = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
    if (done) done_seen++;
  endtask

  task automatic hold(input logic [5:0] lp, input int n);
    for (int i = 0; i < n; i++) step(lp, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lamps   = 6'd0;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);

`ifndef TAILLIGHT_DWELL_CHECK_EN
    //  lamps clr dir    ph done err  l  r  e
    add(6'd1,  0, 2'b01, 1, 0, 0, 0, 0, 0);
    add(6'd1,  0, 2'b01, 1, 0, 0, 0, 0, 0);
    add(6'd3,  0, 2'b01, 2, 0, 0, 0, 0, 0);
    add(6'd7,  0, 2'b01, 3, 0, 0, 0, 0, 0);
    add(6'd0,  0, 2'b00, 0, 1, 0, 1, 0, 0);
    add(6'd0,  0, 2'b00, 0, 0, 0, 1, 0, 0);
    add(6'd8,  0, 2'b10, 1, 0, 0, 1, 0, 0);
    add(6'd24, 0, 2'b10, 2, 0, 0, 1, 0, 0);
    add(6'd56, 0, 2'b10, 3, 0, 0, 1, 0, 0);
    add(6'd0,  0, 2'b00, 0, 1, 0, 1, 1, 0);
    add(6'd1,  0, 2'b01, 1, 0, 0, 1, 1, 0);
    add(6'd7,  0, 2'b11, 0, 0, 1, 1, 1, 1); // skipped L2
    add(6'd3,  0, 2'b11, 0, 0, 1, 1, 1, 1); // stays ERR, not re-counted
    add(6'd0,  0, 2'b00, 0, 0, 1, 1, 1, 1); // recovery, err sticky
    add(6'd0,  1, 2'b00, 0, 0, 0, 0, 0, 0);
    add(6'd1,  0, 2'b01, 1, 0, 0, 0, 0, 0);
    add(6'd3,  0, 2'b01, 2, 0, 0, 0, 0, 0);
    add(6'd7,  0, 2'b01, 3, 0, 0, 0, 0, 0);
    add(6'd0,  1, 2'b00, 0, 1, 0, 0, 0, 0); // clr beats the count, done still pulses
    add(6'd8,  0, 2'b10, 1, 0, 0, 0, 0, 0);
    add(6'd3,  1, 2'b11, 0, 0, 0, 0, 0, 0); // clr beats the error entry
    add(6'd3,  0, 2'b11, 0, 0, 0, 0, 0, 0);
    add(6'd0,  0, 2'b00, 0, 0, 0, 0, 0, 0);
    add(6'd2,  0, 2'b11, 0, 0, 1, 0, 0, 1); // illegal start
    add(6'd0,  0, 2'b00, 0, 0, 1, 0, 0, 1);
    add(6'd8,  0, 2'b10, 1, 0, 1, 0, 0, 1);
    add(6'd56, 0, 2'b11, 0, 0, 1, 0, 0, 2); // skipped R2
    add(6'd0,  0, 2'b00, 0, 0, 1, 0, 0, 2);
    foreach (vecs[i]) begin
      step(vecs[i].lamps, vecs[i].clr);
      check_all($sformatf("vec%0d", i), int'(vecs[i].dir), int'(vecs[i].phase),
                int'(vecs[i].done), int'(vecs[i].err), vecs[i].l, vecs[i].r, vecs[i].e);
    end
`endif

    // Five slow left sequences: counter saturates at 3, done pulses each time.
    step(6'd0, 1'b1);
    hold(6'd0, 2);
    done_seen = 0;
    for (int s = 0; s < 5; s++) begin
      hold(6'd1, 20);
      check($sformatf("seq%0d.ph1", s), int'(phase), 1);
      hold(6'd3, 20);
      check($sformatf("seq%0d.ph2", s), int'(phase), 2);
      hold(6'd7, 20);
      check($sformatf("seq%0d.dir", s), int'(dir), 1);
      hold(6'd0, 20);
    end
    check("sat.left_cnt", int'(left_cnt), 3);
    check("sat.done_pulses", done_seen, 5);
    check("sat.err", int'(err), 0);
    step(6'd0, 1'b1);
    check("clr.left_cnt", int'(left_cnt), 0);
    check("clr.err", int'(err), 0);

    // Error counter saturation: four separate entries.
    for (int k = 0; k < 4; k++) begin
      step(6'd2, 1'b0);
      step(6'd0, 1'b0);
    end
    check("errsat.err_cnt", int'(err_cnt), 3);
    check("errsat.err", int'(err), 1);

    // Asynchronous reset mid-sequence.
    hold(6'd1, 20);
    hold(6'd3, 20);
    check("mid.phase", int'(phase), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    lamps = 6'd0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    step(6'd0, 1'b0);
    check_all("rst_rel0", 0, 0, 0, 0, 0, 0, 0);

    // Reset released with an illegal non-zero pattern on the bus.
    reset_n = 1'b0;
    lamps   = 6'd5;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    step(6'd5, 1'b0);
    check("rst_rel5.dir", int'(dir), 3);
    check("rst_rel5.err_cnt", int'(err_cnt), 1);
    hold(6'd0, 2);
    check("rst_rel5.recover", int'(dir), 0);

`ifdef TAILLIGHT_DWELL_CHECK_EN
    step(6'd0, 1'b1);
    hold(6'd1, 5);
    step(6'd3, 1'b0);
    check("dwell5.dir", int'(dir), 3);
    check("dwell5.err_cnt", int'(err_cnt), 1);
    hold(6'd0, 20);
    hold(6'd1, 15);
    step(6'd3, 1'b0);
    check("dwell15.dir", int'(dir), 3);
    check("dwell15.err_cnt", int'(err_cnt), 2);
    hold(6'd0, 20);
    hold(6'd1, 16);
    step(6'd3, 1'b0);
    check("dwell16.dir", int'(dir), 1);
    check("dwell16.phase", int'(phase), 2);
    check("dwell16.err_cnt", int'(err_cnt), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
